parking_sensor_debounce: RTL and testbench



---
 rtl/parking_sensor_debounce.sv | 84 ++++++++
 tb/tb_parking_sensor_debounce.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_sensor_debounce.sv
// Per-channel two-flop synchronizer, debounce counter and sticky change events for
// the parking-lot sensor lines, plus a registered count of occupied bays.
module parking_sensor_debounce #(
  parameter int N_CH      = 32,
  parameter int CNT_W     = 16,
  parameter int DB_CYCLES = 1000,
  parameter int OCC_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   sensor_raw,
  output logic [N_CH-1:0]   gpio_stable,
  output logic [N_CH-1:0]   event_pending,
  output logic              event_any,
  input  logic              event_clr_en,
  input  logic [N_CH-1:0]   event_clr,
  output logic [OCC_W-1:0]  occupancy
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DB_CYCLES - 1);

  logic [N_CH-1:0]  s1_q, s1_d;
  logic [N_CH-1:0]  s2_q, s2_d;
  logic [N_CH-1:0]  stable_q, stable_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  flip;
  logic [N_CH-1:0]  clr_mask;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    s1_d     = sensor_raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    occ_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      // Any sample agreeing with the stable value restarts the count.
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == TERM_CNT) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    flip     = stable_d ^ stable_q;
    clr_mask = event_clr_en ? event_clr : '0;
    // Set is OR-ed in after the clear so a same-edge set wins.
    pend_d   = (pend_q & ~clr_mask) | flip;
    for (int i = 0; i < N_CH; i++) begin
      occ_d = occ_d + OCC_W'(stable_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      pend_q   <= '0;
      occ_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      occ_q    <= occ_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gpio_stable   = stable_q;
  assign event_pending = pend_q;
  assign event_any     = |pend_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_parking_sensor_debounce.sv
// Bench for parking_sensor_debounce: directed scenarios plus randomized traffic,
// all checked against a sliding-window reference model of the debounce rule.
module tb_parking_sensor_debounce;

  localparam int N  = 4;
  localparam int DB = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] sensor_raw;
  logic [N-1:0] gpio_stable;
  logic [N-1:0] event_pending;
  logic         event_any;
  logic         event_clr_en;
  logic [N-1:0] event_clr;
  logic [2:0]   occupancy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  parking_sensor_debounce #(
    .N_CH(N), .CNT_W(16), .DB_CYCLES(DB), .OCC_W(3)
  ) dut (
    .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .gpio_stable(gpio_stable),
    .event_pending(event_pending), .event_any(event_any),
    .event_clr_en(event_clr_en), .event_clr(event_clr), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw is seen two edges late; a channel flips once the last
  // DB seen samples all disagree with its stable value and at least DB edges
  // have passed since its last flip or reset.
  logic [N-1:0] m_h1, m_h2, m_stable, m_pend, m_v, m_flips, m_clr;
  logic [2:0]   m_occ;
  int           m_since [N];
  logic [N-1:0] m_win [$];
  bit           m_alldiff;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_stable = '0; m_pend = '0; m_occ = '0;
      m_win.delete();
      for (int i = 0; i < N; i++) m_since[i] = 0;
    end else begin
      m_v  = m_h2;
      m_h2 = m_h1;
      m_h1 = sensor_raw;
      m_occ = 3'($countones(m_stable));
      m_win.push_back(m_v);
      if (m_win.size() > DB) void'(m_win.pop_front());
      m_flips = '0;
      for (int i = 0; i < N; i++) begin
        if (m_since[i] < 100000) m_since[i]++;
        m_alldiff = 1'b1;
        foreach (m_win[j]) if (m_win[j][i] == m_stable[i]) m_alldiff = 1'b0;
        if (m_since[i] >= DB && m_win.size() == DB && m_alldiff) begin
          m_flips[i]  = 1'b1;
          m_since[i]  = 0;
        end
      end
      m_clr    = event_clr_en ? event_clr : '0;
      m_pend   = (m_pend & ~m_clr) | m_flips;
      m_stable = m_stable ^ m_flips;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sensor_raw = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({gpio_stable, event_pending, event_any, occupancy} !== 12'h0) begin
        n_bad++;
        $display("FAIL reset_hold cyc %0d: got st=%h ev=%h any=%b occ=%0d want all 0",
                 cyc, gpio_stable, event_pending, event_any, occupancy);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      n_cmp++;
      if (gpio_stable !== ((e >= 6) ? 4'hF : 4'h0) ||
          event_pending !== ((e >= 6) ? 4'hF : 4'h0) ||
          occupancy !== ((e >= 7) ? 3'd4 : 3'd0)) begin
        n_bad++;
        $display("FAIL reset_release edge %0d: got st=%h ev=%h occ=%0d", e,
                 gpio_stable, event_pending, occupancy);
      end
    end
  endtask

  task automatic settle_zero();
    sensor_raw = 4'h0;
    for (int i = 0; i < 8; i++) step();
    event_clr_en = 1'b1; event_clr = 4'hF;
    step();
    event_clr_en = 1'b0; event_clr = 4'h0;
  endtask

  task automatic test_step();
    settle_zero();
    sensor_raw = 4'h1;
    for (int e = 0; e <= 6; e++) begin
      step();
      n_cmp++;
      if (gpio_stable[0] !== (e >= 5) || event_pending[0] !== (e >= 5) ||
          event_any !== (e >= 5) || occupancy !== ((e >= 6) ? 3'd1 : 3'd0)) begin
        n_bad++;
        $display("FAIL step_ch0 edge k+%0d: got st=%h ev=%h any=%b occ=%0d", e,
                 gpio_stable, event_pending, event_any, occupancy);
      end
    end
  endtask

  task automatic test_glitch();
    settle_zero();
    for (int w = 3; w <= 4; w++) begin
      sensor_raw = 4'h2;
      for (int i = 0; i < w; i++) step();
      sensor_raw = 4'h0;
      for (int i = 0; i < 10; i++) begin
        step();
        n_cmp++;
        if ({gpio_stable, event_pending, event_any, occupancy} !==
            {m_stable, m_pend, |m_pend, m_occ}) begin
          n_bad++;
          $display("FAIL glitch_w%0d cyc %0d: got st=%h ev=%h occ=%0d want st=%h ev=%h occ=%0d",
                   w, cyc, gpio_stable, event_pending, occupancy, m_stable, m_pend, m_occ);
        end
      end
      n_cmp++;
      if (gpio_stable[1] !== 1'b0 || event_pending[1] !== (w == 4)) begin
        n_bad++;
        $display("FAIL glitch_end_w%0d: got st1=%b ev1=%b want st1=0 ev1=%b",
                 w, gpio_stable[1], event_pending[1], w == 4);
      end
    end
  endtask

  task automatic test_clear_collision();
    settle_zero();
    sensor_raw = 4'h4;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (event_pending !== 4'h0) begin
      n_bad++;
      $display("FAIL collide_pre: got ev=%h want 0", event_pending);
    end
    event_clr_en = 1'b1; event_clr = 4'b0100;
    step();
    n_cmp++;
    if (event_pending[2] !== 1'b1 || gpio_stable[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL collide_set_wins: got ev2=%b st2=%b want 1 1",
               event_pending[2], gpio_stable[2]);
    end
    step();
    event_clr_en = 1'b0; event_clr = 4'h0;
    n_cmp++;
    if (event_pending !== 4'h0 || event_any !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_clear: got ev=%h any=%b want 0 0", event_pending, event_any);
    end
  endtask

  task automatic test_simultaneous();
    settle_zero();
    sensor_raw = 4'hF;
    for (int e = 0; e <= 6; e++) begin
      step();
      n_cmp++;
      if (gpio_stable !== ((e >= 5) ? 4'hF : 4'h0) ||
          event_pending !== ((e >= 5) ? 4'hF : 4'h0) ||
          occupancy !== ((e >= 6) ? 3'd4 : 3'd0)) begin
        n_bad++;
        $display("FAIL simultaneous edge k+%0d: got st=%h ev=%h occ=%0d",
                 e, gpio_stable, event_pending, occupancy);
      end
    end
  endtask

  task automatic test_reset_mid();
    settle_zero();
    sensor_raw = 4'h8;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_cmp++;
      if (gpio_stable !== ((e >= 6) ? 4'h8 : 4'h0) ||
          event_pending !== ((e >= 6) ? 4'h8 : 4'h0)) begin
        n_bad++;
        $display("FAIL reset_mid edge %0d: got st=%h ev=%h", e, gpio_stable, event_pending);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) sensor_raw[i] = ~sensor_raw[i];
      event_clr_en = ($urandom_range(3) == 0);
      event_clr    = 4'($urandom);
      rst          = ($urandom_range(149) == 0);
      step();
      n_cmp++;
      if ({gpio_stable, event_pending, event_any, occupancy} !==
          {m_stable, m_pend, |m_pend, m_occ}) begin
        n_bad++;
        $display("FAIL random cyc %0d: got st=%h ev=%h any=%b occ=%0d want st=%h ev=%h any=%b occ=%0d",
                 cyc, gpio_stable, event_pending, event_any, occupancy,
                 m_stable, m_pend, |m_pend, m_occ);
      end
    end
    rst = 1'b0; event_clr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sensor_raw = '0; event_clr_en = 1'b0; event_clr = '0;
    test_reset();
    test_step();
    test_glitch();
    test_clear_collision();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
